shot_slot_scheduler: RTL and testbench
======================================

SHOT_SLOT_SCHEDULER -- requirements
Module: shot_slot_scheduler

Interface
REQ-001 SHALL have parameter COOLDOWN_FRAMES, default 4, minimum frames between two launches.
REQ-002 SHALL have parameter MAX_AMMO, default 9, magazine capacity (1..15).
REQ-003 SHALL have parameter RELOAD_FRAMES, default 30, frames to regain one round (1..255).
REQ-004 SHALL have port clk  in  1  system clock, all state on rising edge.
REQ-005 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-006 SHALL have port startOfFrame  in  1  one-cycle pulse per frame.
REQ-007 SHALL have port fireRequest  in  1  player fire key, level.
REQ-008 SHALL have port shotHit  in  3  per-slot collision pulse (shot vs enemy/tower, bit i = slot i).
REQ-009 SHALL have port shotOffScreen  in  3  per-slot level, shot i left the screen.
REQ-010 SHALL have port shotLaunch  out  3  one-hot, one-cycle pulse starting shot slot i.
REQ-011 SHALL have port shotActive  out  3  bit i high while slot i is ACTIVE.
REQ-012 SHALL have port ammoCount  out  4  rounds currently available.
REQ-013 SHALL have port fireDenied  out  1  one-cycle pulse, fire edge arrived with ammoCount==0.

Function
REQ-014 Fire detect: rising edge of fireRequest (registered previous value) SHALL set pending; further edges while pending SHALL be absorbed (queue depth 1).
REQ-015 Launch condition, evaluated every cycle: pending && cooldown==0 && ammoCount>0 && at least one slot FREE.
REQ-016 On launch: exactly one shotLaunch bit SHALL pulse that cycle; pending cleared; slot -> ACTIVE next cycle; ammoCount -1; cooldown loaded with COOLDOWN_FRAMES.
REQ-017 Slot selection SHALL be round-robin: search lastSlot+1, +2, +3 (mod 3), first FREE wins; lastSlot updated to winner.
REQ-018 Per-slot FSM states FREE, ACTIVE, RETIRE: FREE->ACTIVE on launch; ACTIVE->RETIRE on shotHit[i] or shotOffScreen[i]; RETIRE->FREE on next startOfFrame.
REQ-019 shotHit/shotOffScreen on a FREE or RETIRE slot SHALL be ignored.
REQ-020 A slot entering RETIRE in the same cycle as startOfFrame SHALL stay RETIRE until the following startOfFrame (one full frame blanked).
REQ-021 cooldown (8-bit) SHALL decrement by 1 on startOfFrame when nonzero; load on launch wins over same-cycle decrement.
REQ-022 Reload: reloadCnt (8-bit) SHALL increment on startOfFrame while ammoCount<MAX_AMMO; on reaching RELOAD_FRAMES it SHALL clear and ammoCount +1.
REQ-023 ammoCount==MAX_AMMO SHALL hold reloadCnt at 0; ammoCount never exceeds MAX_AMMO nor underflows 0.
REQ-024 Launch and reload-increment in the same cycle SHALL leave ammoCount unchanged (net 0).
REQ-025 Fire edge with ammoCount==0 SHALL pulse fireDenied and SHALL NOT set pending; existing pending SHALL remain.
REQ-026 Pending with all slots non-FREE SHALL wait; launch occurs first cycle a slot is FREE and other conditions hold.
REQ-027 All outputs SHALL be registered; shotLaunch appears the cycle after the enabling condition is sampled.

Reset
REQ-028 While reset high: all slots FREE, shotActive=0, shotLaunch=0, fireDenied=0, pending=0, cooldown=0, reloadCnt=0, lastSlot=2 (first launch uses slot 0), ammoCount=MAX_AMMO, fire edge register=0.
REQ-029 Reset asserted mid-flight SHALL abort all shots immediately (asynchronous) with no launch pulse on release.
REQ-030 fireRequest held high through reset release SHALL NOT produce a launch (edge register cleared to 0 counts as low only after one sampled cycle of low).

Verification
REQ-031 Reset, single fireRequest rise -> shotLaunch=3'b001 one cycle, shotActive=3'b001, ammoCount=8.
REQ-032 Fire edges every frame for 4 frames, COOLDOWN_FRAMES=4 -> launches on slots 0,1,2 spaced 4 frames; fourth edge waits (pending) until a slot frees.
REQ-033 Slot 1 ACTIVE, shotHit=3'b010 -> RETIRE; shotActive[1]=0; next startOfFrame -> FREE; next launch selects slot 2 before slot 1 (round-robin).
REQ-034 Drain ammo to 0, fire edge -> fireDenied pulse, no launch; after 30 startOfFrame pulses ammoCount=1 and a new edge launches.
REQ-035 Launch coincident with reload completion at ammoCount=5 -> ammoCount stays 5, reloadCnt=0.
REQ-036 Assert reset with 2 shots ACTIVE and pending set -> shotActive=0, ammoCount=9 immediately; no shotLaunch after release with fireRequest held high.

Source files
------------

// File: rtl/shot_slot_scheduler.sv
//==============================================================================
// Module      : shot_slot_scheduler
// Description : Three-slot player shot scheduler with fire-edge queue,
//               launch cooldown, magazine and frame-based reload.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module shot_slot_scheduler #(
    parameter int COOLDOWN_FRAMES = 4,
    parameter int MAX_AMMO        = 9,
    parameter int RELOAD_FRAMES   = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       startOfFrame,
    input  logic       fireRequest,
    input  logic [2:0] shotHit,
    input  logic [2:0] shotOffScreen,
    output logic [2:0] shotLaunch,
    output logic [2:0] shotActive,
    output logic [3:0] ammoCount,
    output logic       fireDenied
);

    localparam logic [7:0] c_cooldown_load = 8'(COOLDOWN_FRAMES);
    localparam logic [3:0] c_max_ammo      = 4'(MAX_AMMO);
    localparam logic [7:0] c_reload_frames = 8'(RELOAD_FRAMES);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_RETIRE = 2'd2
    } slot_state_t;

    logic       r_fire_prev;
    logic       r_fire_armed;
    logic       r_pending;
    logic [7:0] r_cooldown;
    logic [7:0] r_reload_cnt;
    logic [1:0] r_last_slot;
    logic [3:0] r_ammo;
    logic [2:0] r_launch;
    logic       r_denied;

    logic [2:0] w_free;
    logic [1:0] w_pick;
    logic       w_fire_edge;
    logic       w_launch_ok;
    logic [2:0] w_launch_vec;
    logic       w_reload_tick;
    logic       w_reload_done;

    function automatic logic [1:0] f_slot_after(input logic [1:0] base, input int step);
        f_slot_after = 2'((int'(base) + step) % 3);
    endfunction

    // A level held high across reset release must first be seen low before it can count as an edge.
    assign w_fire_edge   = fireRequest && !r_fire_prev && r_fire_armed;
    assign w_launch_ok   = r_pending && (r_cooldown == 8'd0) && (r_ammo != 4'd0) && (|w_free);
    assign w_launch_vec  = w_launch_ok ? (3'b001 << w_pick) : 3'b000;
    assign w_reload_tick = startOfFrame && (r_ammo < c_max_ammo);
    assign w_reload_done = w_reload_tick && ((r_reload_cnt + 8'd1) == c_reload_frames);

    // Descending scan so the nearest slot after the last winner overrides the others.
    always_comb begin
        w_pick = r_last_slot;
        for (int k = 3; k >= 1; k--) begin
            if (w_free[f_slot_after(r_last_slot, k)]) begin
                w_pick = f_slot_after(r_last_slot, k);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fire_prev  <= 1'b0;
            r_fire_armed <= 1'b0;
            r_pending    <= 1'b0;
            r_cooldown   <= 8'd0;
            r_reload_cnt <= 8'd0;
            r_last_slot  <= 2'd2;
            r_ammo       <= c_max_ammo;
            r_launch     <= 3'b000;
            r_denied     <= 1'b0;
        end else begin
            r_fire_prev <= fireRequest;
            if (!fireRequest) begin
                r_fire_armed <= 1'b1;
            end
            r_denied <= w_fire_edge && (r_ammo == 4'd0);
            r_launch <= w_launch_vec;

            if (w_launch_ok) begin
                r_pending   <= 1'b0;
                r_last_slot <= w_pick;
            end else if (w_fire_edge && (r_ammo != 4'd0)) begin
                r_pending <= 1'b1;
            end

            if (w_launch_ok) begin
                r_cooldown <= c_cooldown_load;
            end else if (startOfFrame && (r_cooldown != 8'd0)) begin
                r_cooldown <= r_cooldown - 8'd1;
            end

            if (r_ammo == c_max_ammo) begin
                r_reload_cnt <= 8'd0;
            end else if (w_reload_tick) begin
                r_reload_cnt <= w_reload_done ? 8'd0 : r_reload_cnt + 8'd1;
            end

            case ({w_reload_done, w_launch_ok})
                2'b10:   r_ammo <= r_ammo + 4'd1;
                2'b01:   r_ammo <= r_ammo - 4'd1;
                default: r_ammo <= r_ammo;
            endcase
        end
    end

    for (genvar gi = 0; gi < 3; gi++) begin : g_slot
        slot_state_t r_state;
        logic        r_active;

        always_ff @(posedge clk or posedge reset) begin
            if (reset) begin
                r_state  <= S_FREE;
                r_active <= 1'b0;
            end else begin
                case (r_state)
                    S_FREE: begin
                        if (w_launch_vec[gi]) begin
                            r_state  <= S_ACTIVE;
                            r_active <= 1'b1;
                        end
                    end
                    S_ACTIVE: begin
                        if (shotHit[gi] || shotOffScreen[gi]) begin
                            r_state  <= S_RETIRE;
                            r_active <= 1'b0;
                        end
                    end
                    S_RETIRE: begin
                        if (startOfFrame) begin
                            r_state <= S_FREE;
                        end
                    end
                    default: begin
                        r_state  <= S_FREE;
                        r_active <= 1'b0;
                    end
                endcase
            end
        end

        assign w_free[gi]     = (r_state == S_FREE);
        assign shotActive[gi] = r_active;
    end

    assign shotLaunch = r_launch;
    assign ammoCount  = r_ammo;
    assign fireDenied = r_denied;

endmodule

`default_nettype wire

// File: tb/tb_shot_slot_scheduler.sv
//==============================================================================
// Module      : tb_shot_slot_scheduler
// Description : Directed self-checking bench for shot_slot_scheduler.
// Revision    : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_shot_slot_scheduler;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       startOfFrame = 1'b0;
    logic       fireRequest = 1'b0;
    logic [2:0] shotHit = 3'b000;
    logic [2:0] shotOffScreen = 3'b000;
    logic [2:0] shotLaunch;
    logic [2:0] shotActive;
    logic [3:0] ammoCount;
    logic       fireDenied;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    shot_slot_scheduler #(
        .COOLDOWN_FRAMES(4),
        .MAX_AMMO       (9),
        .RELOAD_FRAMES  (30)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .startOfFrame (startOfFrame),
        .fireRequest  (fireRequest),
        .shotHit      (shotHit),
        .shotOffScreen(shotOffScreen),
        .shotLaunch   (shotLaunch),
        .shotActive   (shotActive),
        .ammoCount    (ammoCount),
        .fireDenied   (fireDenied)
    );

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic sof();
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
    endtask

    task automatic sofs(input int n);
        repeat (n) sof();
    endtask

    task automatic fire_pulse();
        fireRequest = 1'b1;
        cyc(1);
        fireRequest = 1'b0;
        cyc(1);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        fireRequest = 1'b0;
        startOfFrame = 1'b0;
        shotHit = 3'b000;
        shotOffScreen = 3'b000;
        cyc(2);
        reset = 1'b0;
        cyc(1);
    endtask

    // Launch, retire that shot off-screen, then let four frames pass.
    task automatic shot_cycle(input logic [2:0] exp_slot, input logic [3:0] exp_ammo, input string tag);
        fire_pulse();
        total++;
        if (shotLaunch !== exp_slot) begin
            bad++;
            $display("FAIL %s launch: got %b want %b", tag, shotLaunch, exp_slot);
        end
        total++;
        if (ammoCount !== exp_ammo) begin
            bad++;
            $display("FAIL %s ammo: got %0d want %0d", tag, ammoCount, exp_ammo);
        end
        shotOffScreen = exp_slot;
        cyc(1);
        shotOffScreen = 3'b000;
        sofs(4);
    endtask

    task automatic test_reset();
        reset = 1'b1;
        cyc(2);
        total++;
        if (shotActive !== 3'b000) begin bad++; $display("FAIL rst_active: got %b want 000", shotActive); end
        total++;
        if (shotLaunch !== 3'b000) begin bad++; $display("FAIL rst_launch: got %b want 000", shotLaunch); end
        total++;
        if (fireDenied !== 1'b0) begin bad++; $display("FAIL rst_denied: got %b want 0", fireDenied); end
        total++;
        if (ammoCount !== 4'd9) begin bad++; $display("FAIL rst_ammo: got %0d want 9", ammoCount); end
        reset = 1'b0;
        cyc(1);
        total++;
        if (ammoCount !== 4'd9) begin bad++; $display("FAIL rst_ammo_post: got %0d want 9", ammoCount); end
    endtask

    task automatic test_single_fire();
        do_reset();
        fireRequest = 1'b1;
        cyc(1);
        total++;
        if (shotLaunch !== 3'b000) begin bad++; $display("FAIL single_early: got %b want 000", shotLaunch); end
        fireRequest = 1'b0;
        cyc(1);
        total++;
        if (shotLaunch !== 3'b001) begin bad++; $display("FAIL single_launch: got %b want 001", shotLaunch); end
        total++;
        if (shotActive !== 3'b001) begin bad++; $display("FAIL single_active: got %b want 001", shotActive); end
        total++;
        if (ammoCount !== 4'd8) begin bad++; $display("FAIL single_ammo: got %0d want 8", ammoCount); end
        cyc(1);
        total++;
        if (shotLaunch !== 3'b000) begin bad++; $display("FAIL single_pulse_len: got %b want 000", shotLaunch); end
        total++;
        if (shotActive !== 3'b001) begin bad++; $display("FAIL single_hold: got %b want 001", shotActive); end
    endtask

    task automatic test_cooldown();
        logic [2:0] seen [13];
        logic [2:0] exp_mask [13] = '{3'b001, 3'b000, 3'b000, 3'b000, 3'b010, 3'b000, 3'b000,
                                      3'b000, 3'b100, 3'b000, 3'b000, 3'b000, 3'b000};
        int pulses;
        do_reset();
        pulses = 0;
        for (int f = 0; f < 13; f++) begin
            seen[f] = 3'b000;
            for (int s = 0; s < 4; s++) begin
                fireRequest  = (s == 0) && (f <= 9);
                startOfFrame = (s == 3);
                cyc(1);
                seen[f] |= shotLaunch;
                if (shotLaunch != 3'b000) pulses++;
            end
            fireRequest  = 1'b0;
            startOfFrame = 1'b0;
        end
        for (int f = 0; f < 13; f++) begin
            total++;
            if (seen[f] !== exp_mask[f]) begin
                bad++;
                $display("FAIL cooldown_frame%0d: got %b want %b", f, seen[f], exp_mask[f]);
            end
        end
        total++;
        if (pulses != 3) begin bad++; $display("FAIL cooldown_pulses: got %0d want 3", pulses); end
        total++;
        if (shotActive !== 3'b111) begin bad++; $display("FAIL cooldown_full: got %b want 111", shotActive); end
        total++;
        if (ammoCount !== 4'd6) begin bad++; $display("FAIL cooldown_ammo: got %0d want 6", ammoCount); end
        shotHit = 3'b010;
        cyc(1);
        shotHit = 3'b000;
        total++;
        if (shotActive !== 3'b101) begin bad++; $display("FAIL cooldown_retire: got %b want 101", shotActive); end
        sof();
        cyc(1);
        total++;
        if (shotLaunch !== 3'b010) begin bad++; $display("FAIL cooldown_waited: got %b want 010", shotLaunch); end
        total++;
        if (ammoCount !== 4'd5) begin bad++; $display("FAIL cooldown_ammo2: got %0d want 5", ammoCount); end
    endtask

    task automatic test_round_robin();
        logic [2:0] seen;
        do_reset();
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b001) begin bad++; $display("FAIL rr_first: got %b want 001", shotLaunch); end
        sofs(4);
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b010) begin bad++; $display("FAIL rr_second: got %b want 010", shotLaunch); end
        sofs(4);
        shotHit = 3'b110;   // slot 2 is FREE, so its hit must be ignored
        cyc(1);
        shotHit = 3'b000;
        total++;
        if (shotActive !== 3'b001) begin bad++; $display("FAIL rr_retire: got %b want 001", shotActive); end
        sof();
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b100) begin bad++; $display("FAIL rr_skip_to_2: got %b want 100", shotLaunch); end
        total++;
        if (shotActive !== 3'b101) begin bad++; $display("FAIL rr_active3: got %b want 101", shotActive); end
        sofs(4);
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b010) begin bad++; $display("FAIL rr_wrap_to_1: got %b want 010", shotLaunch); end
        total++;
        if (shotActive !== 3'b111) begin bad++; $display("FAIL rr_all: got %b want 111", shotActive); end
        sofs(4);
        shotHit = 3'b001;
        startOfFrame = 1'b1;
        cyc(1);
        shotHit = 3'b000;
        startOfFrame = 1'b0;
        total++;
        if (shotActive !== 3'b110) begin bad++; $display("FAIL rr_sof_retire: got %b want 110", shotActive); end
        fireRequest = 1'b1;
        cyc(1);
        fireRequest = 1'b0;
        seen = 3'b000;
        repeat (3) begin
            cyc(1);
            seen |= shotLaunch;
        end
        total++;
        if (seen !== 3'b000) begin bad++; $display("FAIL rr_blanked: got %b want 000", seen); end
        sof();
        cyc(1);
        total++;
        if (shotLaunch !== 3'b001) begin bad++; $display("FAIL rr_after_blank: got %b want 001", shotLaunch); end
        total++;
        if (ammoCount !== 4'd4) begin bad++; $display("FAIL rr_ammo: got %0d want 4", ammoCount); end
    endtask

    task automatic test_deny_reload();
        int exp_ammo [10] = '{8, 7, 6, 5, 4, 3, 2, 1, 1, 0};
        do_reset();
        for (int k = 0; k < 10; k++) begin
            shot_cycle(3'b001 << (k % 3), 4'(exp_ammo[k]), $sformatf("drain%0d", k));
        end
        total++;
        if (ammoCount !== 4'd0) begin bad++; $display("FAIL deny_empty: got %0d want 0", ammoCount); end
        fireRequest = 1'b1;
        cyc(1);
        total++;
        if (fireDenied !== 1'b1) begin bad++; $display("FAIL deny_pulse: got %b want 1", fireDenied); end
        fireRequest = 1'b0;
        cyc(1);
        total++;
        if (fireDenied !== 1'b0) begin bad++; $display("FAIL deny_pulse_len: got %b want 0", fireDenied); end
        total++;
        if (shotLaunch !== 3'b000) begin bad++; $display("FAIL deny_nolaunch: got %b want 000", shotLaunch); end
        sofs(19);
        total++;
        if (ammoCount !== 4'd0) begin bad++; $display("FAIL deny_reload_early: got %0d want 0", ammoCount); end
        sof();
        total++;
        if (ammoCount !== 4'd1) begin bad++; $display("FAIL deny_reload_done: got %0d want 1", ammoCount); end
        cyc(1);
        total++;
        if (shotLaunch !== 3'b000) begin bad++; $display("FAIL deny_no_stale: got %b want 000", shotLaunch); end
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b010) begin bad++; $display("FAIL deny_relaunch: got %b want 010", shotLaunch); end
        total++;
        if (ammoCount !== 4'd0) begin bad++; $display("FAIL deny_relaunch_ammo: got %0d want 0", ammoCount); end
    endtask

    task automatic test_coincident();
        do_reset();
        for (int k = 0; k < 4; k++) begin
            shot_cycle(3'b001 << (k % 3), 4'(8 - k), $sformatf("coin%0d", k));
        end
        sofs(13);
        total++;
        if (ammoCount !== 4'd5) begin bad++; $display("FAIL coin_pre: got %0d want 5", ammoCount); end
        fireRequest = 1'b1;
        cyc(1);
        fireRequest = 1'b0;
        startOfFrame = 1'b1;
        cyc(1);
        startOfFrame = 1'b0;
        total++;
        if (shotLaunch !== 3'b010) begin bad++; $display("FAIL coin_launch: got %b want 010", shotLaunch); end
        total++;
        if (ammoCount !== 4'd5) begin bad++; $display("FAIL coin_net0: got %0d want 5", ammoCount); end
        sofs(29);
        total++;
        if (ammoCount !== 4'd5) begin bad++; $display("FAIL coin_cnt_cleared: got %0d want 5", ammoCount); end
        sof();
        total++;
        if (ammoCount !== 4'd6) begin bad++; $display("FAIL coin_next_reload: got %0d want 6", ammoCount); end
    endtask

    task automatic test_reset_midflight();
        logic [2:0] seen;
        do_reset();
        fire_pulse();
        sofs(4);
        fire_pulse();
        fireRequest = 1'b1;
        cyc(1);
        total++;
        if (shotActive !== 3'b011) begin bad++; $display("FAIL mid_pre: got %b want 011", shotActive); end
        #2;
        reset = 1'b1;
        #1;
        total++;
        if (shotActive !== 3'b000) begin bad++; $display("FAIL mid_abort: got %b want 000", shotActive); end
        total++;
        if (ammoCount !== 4'd9) begin bad++; $display("FAIL mid_ammo: got %0d want 9", ammoCount); end
        cyc(2);
        reset = 1'b0;
        seen = 3'b000;
        for (int i = 0; i < 6; i++) begin
            startOfFrame = (i == 2);
            cyc(1);
            seen |= shotLaunch;
        end
        startOfFrame = 1'b0;
        total++;
        if (seen !== 3'b000) begin bad++; $display("FAIL mid_held_fire: got %b want 000", seen); end
        fireRequest = 1'b0;
        cyc(1);
        fire_pulse();
        total++;
        if (shotLaunch !== 3'b001) begin bad++; $display("FAIL mid_relaunch: got %b want 001", shotLaunch); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "time limit");
    end

    initial begin
        test_reset();
        test_single_fire();
        test_cooldown();
        test_round_robin();
        test_deny_reload();
        test_coincident();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
